rx_smi_sched: RTL and testbench
===============================

Name: rx_smi_sched

Overview:
- Drains the two 32-bit RX sample FIFOs (0.9 GHz and 2.4 GHz channels) on the system clock domain.
- Arbitrates between them with burst-limited round-robin.
- Serializes each 32-bit word MSB-first into an 8-bit byte stream with a valid/ready handshake toward the SMI byte port.
- Sits between the read sides of the dual-clock FIFOs and smi_ctrl; configuration bits come from smi_ctrl registers.

Parameters:
- BURST_WORDS, 4, maximum consecutive words taken from one channel before the grant must rotate (≥1).
- CNT_W, 16, width of the per-channel word counters.

Ports:
- i_sys_clk  in  1  system clock; all logic is on this clock.
- i_rst_b  in  1  asynchronous active-low reset.
- i_chan_en  in  2  bit0 = 0.9 GHz channel, bit1 = 2.4 GHz channel enable.
- i_cnt_clr  in  1  synchronous clear of both word counters.
- i_09_empty  in  1  0.9 GHz FIFO empty.
- o_09_pull  out  1  0.9 GHz FIFO read enable, one-cycle pulse.
- i_09_data  in  32  0.9 GHz FIFO read data, valid the cycle after the pull.
- i_24_empty  in  1  2.4 GHz FIFO empty.
- o_24_pull  out  1  2.4 GHz FIFO read enable, one-cycle pulse.
- i_24_data  in  32  2.4 GHz FIFO read data, valid the cycle after the pull.
- o_byte  out  8  serialized byte.
- o_byte_valid  out  1  o_byte is valid.
- i_byte_ready  in  1  consumer accepts o_byte.
- o_chan_id  out  1  channel of the current word (0 = 0.9, 1 = 2.4).
- o_word_start  out  1  high while o_byte is byte 0 of a word.
- o_busy  out  1  state is not IDLE.
- o_09_words  out  CNT_W  words drained from 0.9 GHz, wraps.
- o_24_words  out  CNT_W  words drained from 2.4 GHz, wraps.

Behaviour:
- Reset (async, i_rst_b = 0):
  - State IDLE; all pulls 0; o_byte_valid 0; o_byte 0; o_chan_id 0; o_word_start 0; o_busy 0.
  - Counters 0; burst count 0; round-robin priority points to channel 0.
  - Reset mid-word discards the partial word. The already-pulled FIFO word is lost by design.
- Eligibility: channel k is eligible when i_chan_en[k] = 1 and its empty flag = 0.
- State IDLE, grant selection:
  - Keep the current channel if it is eligible and burst count < BURST_WORDS.
  - Otherwise take the highest-priority eligible channel, reset burst count to 0, and move priority to the other channel after the grant.
  - With none eligible, stay in IDLE.
  - On a grant: assert the granted o_xx_pull for exactly this cycle, latch o_chan_id, then go to FETCH.
- State FETCH:
  - Capture the granted channel's i_xx_data into the shift register.
  - Set byte index to 0, increment that channel's word counter, increment burst count, go to SEND.
- State SEND:
  - o_byte_valid = 1; o_byte = shift register byte [31:24], [23:16], [15:8], [7:0] by index 0..3.
  - o_word_start = (index == 0).
  - Advance only on valid & ready. o_byte and o_byte_valid stay stable while ready = 0.
  - On acceptance of byte 3, return to IDLE; o_byte_valid drops the next cycle.
- Latency:
  - Pull in cycle N, data captured at N+1, first o_byte_valid at N+2.
  - Minimum 6 cycles per word with ready held at 1 (IDLE, FETCH, 4×SEND).
- Never more than one pull per word. Never a pull outside IDLE. Never both pulls in the same cycle.
- i_chan_en change mid-word: the current word completes; the new enable applies at the next IDLE.
- If empty rises between grant and FETCH: impossible, since the pull is only issued when not empty.
- Word counters:
  - Wrap from 2^CNT_W−1 to 0.
  - i_cnt_clr takes priority over an increment in the same cycle, and the word is not counted.
- Burst count saturates at BURST_WORDS. When the other channel is not eligible, the current channel is re-granted with burst count reset.

Decomposition:
- Shared package holds:
  - State encoding IDLE/FETCH/SEND (2-bit).
  - Channel ID constants CH_09 = 0, CH_24 = 1.
  - Default BURST_WORDS.
- One natural sub-module: rr_arb2, the two-requester round-robin arbiter with burst hold (inputs: eligible[1:0], hold; outputs: grant one-hot, priority update).
- Serializer and counters stay in the top of rx_smi_sched.

Test Plan:
- Reset, then both enabled, 0.9 FIFO preloaded with 0xA1B2C3D4 and ready = 1 → o_09_pull pulses once; bytes A1, B2, C3, D4 appear with o_chan_id = 0 and o_word_start only on A1; first valid 2 cycles after the pull; o_09_words = 1.
- Both FIFOs hold 10 words, BURST_WORDS = 4, ready = 1 → word channel order is 0×4, 1×4, 0×4, 1×4, then the remaining words of each; counters end at 10/10.
- Backpressure: ready toggles 1,0,0,1 during word 0x11223344 → o_byte holds 0x22 across the stalls; no byte duplicated or dropped; no new pull until byte 0x44 is accepted.
- Only the 2.4 channel is enabled and both FIFOs are non-empty → only o_24_pull ever asserts; the 0.9 counter stays 0. Enable 0.9 mid-word → that word finishes on the 2.4 channel, and the 0.9 channel is granted after the current burst.
- Assert i_rst_b = 0 during SEND byte 2 → o_byte_valid = 0 immediately (async); after release, state is IDLE and counters are 0.
- Preload counter 0xFFFF, drain one word → o_09_words = 0x0000. Assert i_cnt_clr in the FETCH cycle → the counter reads 0, not 1.

Source files
------------

// File: rtl/rx_smi_sched_pkg.sv
// Shared definitions for the RX sample scheduler: FSM encoding,
// channel identifiers and the default burst length.
package rx_smi_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2
    } state_t;

    localparam logic CH_09 = 1'b0;
    localparam logic CH_24 = 1'b1;

    localparam int DEF_BURST_WORDS = 4;

endpackage

// File: rtl/rx_smi_sched_rr_arb2.sv
// Two-requester round-robin arbiter with burst hold. Purely combinational;
// the priority pointer and burst count live in the parent.
module rr_arb2 (
    input  logic [1:0] eligible,
    input  logic       hold,
    input  logic       cur_chan,
    input  logic       prio,
    output logic [1:0] grant,
    output logic       fresh,
    output logic       prio_next
);

    // Keep the running burst if allowed, else pick by priority and rotate.
    always_comb begin
        grant     = 2'b00;
        fresh     = 1'b0;
        prio_next = prio;
        if (hold && eligible[cur_chan]) begin
            grant[cur_chan] = 1'b1;
        end else if (eligible[prio]) begin
            grant[prio] = 1'b1;
            fresh       = 1'b1;
            prio_next   = ~prio;
        end else if (eligible[~prio]) begin
            // Granted the low-priority side: the other channel is already
            // the priority holder, so the pointer stays put.
            grant[~prio] = 1'b1;
            fresh        = 1'b1;
            prio_next    = prio;
        end
    end

endmodule

// File: rtl/rx_smi_sched.sv
// Drains the 0.9 GHz and 2.4 GHz RX FIFOs with burst-limited round-robin and
// serializes each 32-bit word MSB-first onto the SMI byte port.
module rx_smi_sched
    import rx_smi_sched_pkg::*;
#(
    parameter int BURST_WORDS = DEF_BURST_WORDS,
    parameter int CNT_W       = 16
) (
    input  logic             i_sys_clk,
    input  logic             i_rst_b,
    input  logic [1:0]       i_chan_en,
    input  logic             i_cnt_clr,
    input  logic             i_09_empty,
    output logic             o_09_pull,
    input  logic [31:0]      i_09_data,
    input  logic             i_24_empty,
    output logic             o_24_pull,
    input  logic [31:0]      i_24_data,
    output logic [7:0]       o_byte,
    output logic             o_byte_valid,
    input  logic             i_byte_ready,
    output logic             o_chan_id,
    output logic             o_word_start,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_09_words,
    output logic [CNT_W-1:0] o_24_words
);

    localparam int BW = $clog2(BURST_WORDS + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(BURST_WORDS);

    state_t           state_reg, state_next;
    logic             chan_reg, chan_next;
    logic             prio_reg, prio_next;
    logic [BW-1:0]    burst_reg, burst_next;
    logic [31:0]      shift_reg, shift_next;
    logic [1:0]       idx_reg, idx_next;
    logic [CNT_W-1:0] cnt09_reg, cnt09_next;
    logic [CNT_W-1:0] cnt24_reg, cnt24_next;

    logic [1:0] eligible;
    logic       burst_live;
    logic [1:0] grant;
    logic       fresh;
    logic       arb_prio_next;

    assign eligible = i_chan_en & ~{i_24_empty, i_09_empty};

    // A zero burst count only occurs before the first word after reset, so
    // it must not count as a live burst: the first grant goes through
    // priority and rotates the pointer like any other fresh grant.
    assign burst_live = (burst_reg != '0) && (burst_reg < BURST_MAX);

    rr_arb2 u_arb (
        .eligible  (eligible),
        .hold      (burst_live),
        .cur_chan  (chan_reg),
        .prio      (prio_reg),
        .grant     (grant),
        .fresh     (fresh),
        .prio_next (arb_prio_next)
    );

    assign o_chan_id  = chan_reg;
    assign o_09_words = cnt09_reg;
    assign o_24_words = cnt24_reg;

    // State and datapath registers; reset drops any partially sent word.
    always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            state_reg <= ST_IDLE;
            chan_reg  <= CH_09;
            prio_reg  <= CH_09;
            burst_reg <= '0;
            shift_reg <= '0;
            idx_reg   <= '0;
            cnt09_reg <= '0;
            cnt24_reg <= '0;
        end else begin
            state_reg <= state_next;
            chan_reg  <= chan_next;
            prio_reg  <= prio_next;
            burst_reg <= burst_next;
            shift_reg <= shift_next;
            idx_reg   <= idx_next;
            cnt09_reg <= cnt09_next;
            cnt24_reg <= cnt24_next;
        end
    end

    // Next-state logic and Moore/Mealy outputs of the drain/serialize FSM.
    always_comb begin
        state_next   = state_reg;
        chan_next    = chan_reg;
        prio_next    = prio_reg;
        burst_next   = burst_reg;
        shift_next   = shift_reg;
        idx_next     = idx_reg;
        cnt09_next   = cnt09_reg;
        cnt24_next   = cnt24_reg;
        o_09_pull    = 1'b0;
        o_24_pull    = 1'b0;
        o_byte_valid = 1'b0;
        o_byte       = 8'd0;
        o_word_start = 1'b0;
        o_busy       = (state_reg != ST_IDLE);

        if (i_cnt_clr) begin
            cnt09_next = '0;
            cnt24_next = '0;
        end

        case (state_reg)
            ST_IDLE: begin
                if (grant != 2'b00) begin
                    o_09_pull  = grant[0];
                    o_24_pull  = grant[1];
                    chan_next  = grant[1];
                    if (fresh) begin
                        burst_next = '0;
                        prio_next  = arb_prio_next;
                    end
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                shift_next = (chan_reg == CH_24) ? i_24_data : i_09_data;
                idx_next   = 2'd0;
                // A clear in this cycle wins and swallows this word's count.
                if (!i_cnt_clr) begin
                    if (chan_reg == CH_24) begin
                        cnt24_next = cnt24_reg + CNT_W'(1);
                    end else begin
                        cnt09_next = cnt09_reg + CNT_W'(1);
                    end
                end
                if (burst_reg < BURST_MAX) begin
                    burst_next = burst_reg + BW'(1);
                end
                state_next = ST_SEND;
            end
            ST_SEND: begin
                o_byte_valid = 1'b1;
                o_byte       = shift_reg[31:24];
                o_word_start = (idx_reg == 2'd0);
                if (i_byte_ready) begin
                    shift_next = {shift_reg[23:0], 8'd0};
                    idx_next   = idx_reg + 2'd1;
                    if (idx_reg == 2'd3) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_rx_smi_sched.sv
// Scoreboard bench for rx_smi_sched: FIFO models feed the DUT, expected
// bytes are queued at stimulus time and popped as the DUT hands them over.
module tb_rx_smi_sched;

    localparam int BURST_WORDS = 4;
    localparam int CNT_W       = 8;

    typedef struct {
        logic [7:0] b;
        logic       ch;
        logic       st;
    } exp_t;

    logic             clk = 1'b0;
    logic             i_rst_b = 1'b0;
    logic [1:0]       i_chan_en = 2'b00;
    logic             i_cnt_clr = 1'b0;
    logic             i_09_empty = 1'b1;
    logic             o_09_pull;
    logic [31:0]      i_09_data = '0;
    logic             i_24_empty = 1'b1;
    logic             o_24_pull;
    logic [31:0]      i_24_data = '0;
    logic [7:0]       o_byte;
    logic             o_byte_valid;
    logic             i_byte_ready = 1'b1;
    logic             o_chan_id;
    logic             o_word_start;
    logic             o_busy;
    logic [CNT_W-1:0] o_09_words;
    logic [CNT_W-1:0] o_24_words;

    logic [31:0] q09[$];
    logic [31:0] q24[$];
    exp_t        sb[$];

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    int pull_cyc = 0;
    bit lat_arm = 1'b0;

    rx_smi_sched #(
        .BURST_WORDS (BURST_WORDS),
        .CNT_W       (CNT_W)
    ) dut (
        .i_sys_clk    (clk),
        .i_rst_b      (i_rst_b),
        .i_chan_en    (i_chan_en),
        .i_cnt_clr    (i_cnt_clr),
        .i_09_empty   (i_09_empty),
        .o_09_pull    (o_09_pull),
        .i_09_data    (i_09_data),
        .i_24_empty   (i_24_empty),
        .o_24_pull    (o_24_pull),
        .i_24_data    (i_24_data),
        .o_byte       (o_byte),
        .o_byte_valid (o_byte_valid),
        .i_byte_ready (i_byte_ready),
        .o_chan_id    (o_chan_id),
        .o_word_start (o_word_start),
        .o_busy       (o_busy),
        .o_09_words   (o_09_words),
        .o_24_words   (o_24_words)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // FIFO models: read data appears the cycle after the pull.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (o_09_pull && q09.size() != 0) i_09_data <= q09.pop_front();
        if (o_24_pull && q24.size() != 0) i_24_data <= q24.pop_front();
        i_09_empty <= (q09.size() == 0);
        i_24_empty <= (q24.size() == 0);
    end

    // Monitor: protocol checks on pulls, latency, and byte scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (i_rst_b) begin
            if (o_09_pull || o_24_pull) begin
                chk("dual_pull", {31'd0, o_09_pull & o_24_pull}, 32'd0);
                chk("pull_busy", {31'd0, o_busy}, 32'd0);
                if (o_09_pull) chk("pull_ok09", {31'd0, i_chan_en[0] & ~i_09_empty}, 32'd1);
                if (o_24_pull) chk("pull_ok24", {31'd0, i_chan_en[1] & ~i_24_empty}, 32'd1);
                lat_arm  = 1'b1;
                pull_cyc = cyc;
            end
            if (o_byte_valid && o_word_start && lat_arm) begin
                chk("latency", 32'(cyc - pull_cyc), 32'd2);
                lat_arm = 1'b0;
            end
            if (o_byte_valid) begin
                if (sb.size() == 0) begin
                    chk("sb_depth", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb[0];
                    chk("byte", {24'd0, o_byte}, {24'd0, e.b});
                    chk("chan", {31'd0, o_chan_id}, {31'd0, e.ch});
                    chk("start", {31'd0, o_word_start}, {31'd0, e.st});
                    $display("byte %02h ch%0d start=%0b ready=%0b", o_byte, o_chan_id, o_word_start, i_byte_ready);
                    if (i_byte_ready) e = sb.pop_front();
                end
            end
        end
    end

    task automatic expect_word(input logic ch, input logic [31:0] w);
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            e.b  = w[31-8*k -: 8];
            e.ch = ch;
            e.st = (k == 0);
            sb.push_back(e);
        end
    endtask

    task automatic load_expect(input logic ch, input logic [31:0] w);
        if (ch) q24.push_back(w); else q09.push_back(w);
        expect_word(ch, w);
    endtask

    task automatic apply_reset();
        i_rst_b   = 1'b0;
        i_chan_en = 2'b00;
        i_cnt_clr = 1'b0;
        sb.delete();
        q09.delete();
        q24.delete();
        repeat (2) @(posedge clk);
        #1 i_rst_b = 1'b1;
    endtask

    task automatic drain(input int lim);
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !o_busy && q09.size() == 0 && q24.size() == 0) break;
        end
        chk("drain_left", 32'(sb.size() + q09.size() + q24.size()) + {31'd0, o_busy}, 32'd0);
    endtask

    task automatic wait_byte(input logic [7:0] b, input int lim);
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (o_byte_valid && o_byte == b) break;
        end
        chk("seen_byte", {23'd0, o_byte_valid, o_byte}, {23'd0, 1'b1, b});
    endtask

    task automatic wait_pull09(input int lim);
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (o_09_pull) break;
        end
        chk("seen_pull09", {31'd0, o_09_pull}, 32'd1);
    endtask

    initial begin
        int seq2[20];
        int seq4[9];
        int n0;
        int n1;
        seq2 = '{0,0,0,0, 1,1,1,1, 0,0,0,0, 1,1,1,1, 0,0, 1,1};
        seq4 = '{1,1,1,1, 0,0,0, 1,1};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'd0, o_byte_valid}, 32'd0);
        chk("rst_byte", {24'd0, o_byte}, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_pulls", {30'd0, o_24_pull, o_09_pull}, 32'd0);
        chk("rst_chan", {31'd0, o_chan_id}, 32'd0);
        chk("rst_start", {31'd0, o_word_start}, 32'd0);
        chk("rst_cnt09", 32'(o_09_words), 32'd0);
        chk("rst_cnt24", 32'(o_24_words), 32'd0);
        @(posedge clk); #1 i_rst_b = 1'b1;

        // Single word on the 0.9 channel
        i_chan_en = 2'b11;
        load_expect(1'b0, 32'hA1B2C3D4);
        drain(100);
        chk("t1_cnt09", 32'(o_09_words), 32'd1);
        chk("t1_cnt24", 32'(o_24_words), 32'd0);

        // Burst round-robin with both FIFOs holding 10 words
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            q09.push_back({8'h90 + 8'(i), 24'h09_09_09});
            q24.push_back({8'h40 + 8'(i), 24'h24_24_24});
        end
        n0 = 0;
        n1 = 0;
        for (int i = 0; i < 20; i++) begin
            if (seq2[i] == 0) begin
                expect_word(1'b0, {8'h90 + 8'(n0), 24'h09_09_09});
                n0++;
            end else begin
                expect_word(1'b1, {8'h40 + 8'(n1), 24'h24_24_24});
                n1++;
            end
        end
        i_chan_en = 2'b11;
        drain(400);
        chk("t2_cnt09", 32'(o_09_words), 32'd10);
        chk("t2_cnt24", 32'(o_24_words), 32'd10);

        // Backpressure: ready 1,0,0,1 across the first bytes
        apply_reset();
        i_chan_en = 2'b01;
        load_expect(1'b0, 32'h11223344);
        load_expect(1'b0, 32'h55667788);
        wait_byte(8'h11, 50);
        @(posedge clk); #1 i_byte_ready = 1'b0;
        @(negedge clk); chk("stall1", {24'd0, o_byte}, 32'h22);
        @(posedge clk); #1 i_byte_ready = 1'b0;
        @(negedge clk); chk("stall2", {24'd0, o_byte}, 32'h22);
        chk("stall_valid", {31'd0, o_byte_valid}, 32'd1);
        @(posedge clk); #1 i_byte_ready = 1'b1;
        drain(100);
        chk("t3_cnt09", 32'(o_09_words), 32'd2);

        // 2.4 only, then 0.9 enabled mid-word
        apply_reset();
        for (int i = 0; i < 6; i++) q24.push_back({8'h40 + 8'(i), 24'h24_24_24});
        for (int i = 0; i < 3; i++) q09.push_back({8'h90 + 8'(i), 24'h09_09_09});
        n0 = 0;
        n1 = 0;
        for (int i = 0; i < 9; i++) begin
            if (seq4[i] == 0) begin
                expect_word(1'b0, {8'h90 + 8'(n0), 24'h09_09_09});
                n0++;
            end else begin
                expect_word(1'b1, {8'h40 + 8'(n1), 24'h24_24_24});
                n1++;
            end
        end
        i_chan_en = 2'b10;
        wait_byte(8'h41, 100);
        chk("t4_cnt09_mid", 32'(o_09_words), 32'd0);
        i_chan_en = 2'b11;
        drain(200);
        chk("t4_cnt09", 32'(o_09_words), 32'd3);
        chk("t4_cnt24", 32'(o_24_words), 32'd6);

        // Asynchronous reset while byte 2 is on the port
        apply_reset();
        i_chan_en = 2'b01;
        load_expect(1'b0, 32'hA1B2C3D4);
        wait_byte(8'hC3, 50);
        #2 i_rst_b = 1'b0;
        #1;
        chk("arst_valid", {31'd0, o_byte_valid}, 32'd0);
        chk("arst_busy", {31'd0, o_busy}, 32'd0);
        chk("arst_cnt09", 32'(o_09_words), 32'd0);
        sb.delete();
        q09.delete();
        q24.delete();
        repeat (2) @(posedge clk);
        #1 i_rst_b = 1'b1;
        @(negedge clk);
        chk("arst_idle", {31'd0, o_busy}, 32'd0);
        chk("arst_byte", {24'd0, o_byte}, 32'd0);

        // Counter wrap and clear-in-FETCH
        apply_reset();
        i_chan_en = 2'b01;
        for (int i = 0; i < 255; i++) load_expect(1'b0, 32'h0A000000 | 32'(i));
        drain(2000);
        chk("wrap_pre", 32'(o_09_words), 32'hFF);
        load_expect(1'b0, 32'hCAFEF00D);
        drain(100);
        chk("wrap", 32'(o_09_words), 32'h00);
        load_expect(1'b0, 32'h01020304);
        drain(100);
        chk("clr_pre", 32'(o_09_words), 32'd1);
        load_expect(1'b0, 32'h05060708);
        wait_pull09(50);
        @(posedge clk); #1 i_cnt_clr = 1'b1;
        @(posedge clk); #1 i_cnt_clr = 1'b0;
        chk("clr_fetch", 32'(o_09_words), 32'd0);
        drain(100);
        chk("clr_after", 32'(o_09_words), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
